// File: rtl/header_load_ctrl_pkg.sv
// Shared types and defaults for the block-header load controller.
package hdr_load_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_CORE = 2'd2
    } hl_state_t;

    localparam int HDR_BYTES_DEF      = 80;
    localparam int ADDR_W_DEF         = 7;
    localparam int TIMEOUT_CYCLES_DEF = 100000;

endpackage

// File: rtl/header_load_ctrl_if.sv
// Receiver / hashing-core / header-register signals of the header load controller.
interface header_load_ctrl_if #(
    parameter int ADDR_W = 7
) ();
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              rx_error;
    logic              core_done;
    logic              clear_err;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic [7:0]        load_data;
    logic              hash_start;
    logic              busy;
    logic              overrun;
    logic              frame_err;
    logic              timeout;

    // Environment side: drives received bytes and core status, observes the write port.
    modport master (
        output rx_valid, rx_byte, rx_error, core_done, clear_err,
        input  load, address, load_data, hash_start, busy, overrun, frame_err, timeout
    );

    // Controller side.
    modport slave (
        input  rx_valid, rx_byte, rx_error, core_done, clear_err,
        output load, address, load_data, hash_start, busy, overrun, frame_err, timeout
    );
endinterface

// File: rtl/header_load_ctrl_idle_timer.sv
// Inter-byte gap timer: counts enabled clocks, flags the last allowed idle clock.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic clr,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;

    // Clear wins over counting; the count parks at LAST so it can never wrap.
    always_comb begin
        timer_d = timer_q;
        if (clr)
            timer_d = '0;
        else if (en && (timer_q != LAST))
            timer_d = timer_q + TW'(1);
    end

    // Timer register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            timer_q <= '0;
        else
            timer_q <= timer_d;
    end

    assign expired = en && (timer_q == LAST);
endmodule

// File: rtl/header_load_ctrl.sv
// Sequences received bytes into the 80-byte header register and hands the header to the hashing core.
module header_load_ctrl
    import hdr_load_pkg::*;
#(
    parameter int HDR_BYTES      = HDR_BYTES_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                n_rst,
    header_load_ctrl_if.slave   bus
);
    hl_state_t         state_q, state_d;
    logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
    logic              pend_q, pend_d;         // last byte written, hash_start due next cycle
    logic              load_q, load_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [7:0]        load_data_q, load_data_d;
    logic              hash_start_q, hash_start_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;
    logic              timeout_q, timeout_d;

    logic rx_open, accept, bad_byte, drop_byte, last_byte;
    logic tmr_en, tmr_clr, tmr_expired, tmo;

    // Bytes are taken only while collecting; the completion cycle already belongs to the core.
    assign rx_open   = ((state_q == IDLE) || (state_q == LOAD)) && !pend_q;
    assign accept    = bus.rx_valid && !bus.rx_error && rx_open;
    assign bad_byte  = bus.rx_valid &&  bus.rx_error && rx_open;
    assign drop_byte = bus.rx_valid && !rx_open;
    assign last_byte = (byte_cnt_q == ADDR_W'(HDR_BYTES - 1));

    assign tmr_en  = (state_q == LOAD) && !pend_q;
    assign tmr_clr = bus.rx_valid || !tmr_en;
    assign tmo     = tmr_expired && !bus.rx_valid;

    idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .en      (tmr_en),
        .clr     (tmr_clr),
        .expired (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = LOAD;
            LOAD: begin
                if (pend_q)
                    state_d = WAIT_CORE;
                else if (bad_byte || tmo)
                    state_d = IDLE;
            end
            WAIT_CORE: if (bus.core_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Byte counter, registered write port, hash_start and sticky flags.
    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        pend_d       = 1'b0;
        hash_start_d = pend_q;
        load_d       = accept;
        address_d    = address_q;
        load_data_d  = load_data_q;
        if (accept) begin
            address_d   = byte_cnt_q;
            load_data_d = bus.rx_byte;
            if (last_byte)
                pend_d = 1'b1;              // counter saturates at the header end
            else
                byte_cnt_d = byte_cnt_q + ADDR_W'(1);
        end
        if (bad_byte || tmo || pend_q)
            byte_cnt_d = '0;
        // Setting beats clearing so an event coinciding with clear_err is not lost.
        overrun_d   = drop_byte || (overrun_q   && !bus.clear_err);
        frame_err_d = bad_byte  || (frame_err_q && !bus.clear_err);
        timeout_d   = tmo       || (timeout_q   && !bus.clear_err);
    end

    // Datapath and flag registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_cnt_q   <= '0;
            pend_q       <= 1'b0;
            load_q       <= 1'b0;
            address_q    <= '0;
            load_data_q  <= '0;
            hash_start_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            pend_q       <= pend_d;
            load_q       <= load_d;
            address_q    <= address_d;
            load_data_q  <= load_data_d;
            hash_start_q <= hash_start_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            timeout_q    <= timeout_d;
        end
    end

    // Output decode: busy from state, everything else straight from flops.
    always_comb begin
        bus.busy       = (state_q == LOAD) || (state_q == WAIT_CORE);
        bus.load       = load_q;
        bus.address    = address_q;
        bus.load_data  = load_data_q;
        bus.hash_start = hash_start_q;
        bus.overrun    = overrun_q;
        bus.frame_err  = frame_err_q;
        bus.timeout    = timeout_q;
    end
endmodule

// File: tb/tb_header_load_ctrl.sv
// Scoreboard bench for header_load_ctrl (TIMEOUT_CYCLES reduced to 16).
module tb_header_load_ctrl;
    localparam int HDR = 80;
    localparam int AW  = 7;
    localparam int TMO = 16;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } ld_t;

    logic clk;
    logic n_rst;
    int   cyc;
    int   chk_cnt;
    int   pass_cnt;
    int   exp_addr;
    ld_t  ld_q[$];
    int   hs_q[$];

    header_load_ctrl_if #(.ADDR_W(AW)) bus ();

    header_load_ctrl #(
        .HDR_BYTES      (HDR),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got == exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Drive one byte for exactly one cycle; queue the expected load (and hash_start on the last byte).
    task automatic send(input logic [7:0] b, input logic err, input bit acc);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        bus.rx_error = err;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        if (acc) begin
            ld_q.push_back('{exp_addr, int'(b), cyc});
            $display("tx byte %02h -> expect addr %0d at cycle %0d", b, exp_addr, cyc);
            if (exp_addr == HDR - 1) begin
                hs_q.push_back(cyc + 1);
                exp_addr = 0;
            end else begin
                exp_addr++;
            end
        end else begin
            $display("tx byte %02h err=%0b -> expect no load", b, err);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_done();
        bus.core_done = 1'b1;
        @(posedge clk); #1;
        bus.core_done = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_err = 1'b1;
        @(posedge clk); #1;
        bus.clear_err = 1'b0;
    endtask

    task automatic frame(input int n, input int first, input int gap);
        for (int i = 0; i < n; i++) begin
            send(8'(first + i), 1'b0, 1'b1);
            if (i < n - 1) idle(gap);
        end
    endtask

    // Scoreboard: pop on every load / hash_start the DUT produces.
    always @(negedge clk) begin
        ld_t e;
        if (n_rst) begin
            if (bus.load) begin
                if (ld_q.size() == 0) begin
                    check_eq("unexpected_load", 1, 0);
                end else begin
                    e = ld_q.pop_front();
                    $display("rx load addr %0d data %02h cycle %0d", bus.address, bus.load_data, cyc);
                    check_eq("load_addr", int'(bus.address), e.addr);
                    check_eq("load_data", int'(bus.load_data), e.data);
                    check_eq("load_cycle", cyc, e.cyc);
                end
            end
            if (bus.hash_start) begin
                if (hs_q.size() == 0) begin
                    check_eq("unexpected_hash_start", 1, 0);
                end else begin
                    $display("rx hash_start cycle %0d", cyc);
                    check_eq("hash_start_cycle", cyc, hs_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc           = 0;
        chk_cnt       = 0;
        pass_cnt      = 0;
        exp_addr      = 0;
        n_rst         = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.rx_error  = 1'b0;
        bus.core_done = 1'b0;
        bus.clear_err = 1'b0;
        idle(3);
        check_eq("rst_load", int'(bus.load), 0);
        check_eq("rst_address", int'(bus.address), 0);
        check_eq("rst_load_data", int'(bus.load_data), 0);
        check_eq("rst_hash_start", int'(bus.hash_start), 0);
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_overrun", int'(bus.overrun), 0);
        check_eq("rst_frame_err", int'(bus.frame_err), 0);
        check_eq("rst_timeout", int'(bus.timeout), 0);
        n_rst = 1'b1;
        idle(2);

        // Slow frame, one byte every 10 clocks.
        frame(HDR, 0, 9);
        idle(1);
        check_eq("t1_busy_hash", int'(bus.busy), 1);
        idle(5);
        check_eq("t1_busy_wait", int'(bus.busy), 1);
        pulse_done();
        check_eq("t1_busy_done", int'(bus.busy), 0);
        pulse_done();                         // ignored outside WAIT_CORE
        check_eq("t1_idle_done", int'(bus.busy), 0);

        // Back-to-back frame, then overrun in WAIT_CORE.
        frame(HDR, 8'h80, 0);
        idle(2);
        check_eq("t2_busy", int'(bus.busy), 1);
        for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 1'b0, 1'b0);
        check_eq("t5_overrun", int'(bus.overrun), 1);
        pulse_clear();
        check_eq("t5_overrun_clr", int'(bus.overrun), 0);
        bus.clear_err = 1'b1;
        send(8'hA5, 1'b0, 1'b0);
        bus.clear_err = 1'b0;
        check_eq("t5_set_beats_clr", int'(bus.overrun), 1);
        pulse_clear();
        check_eq("t5_overrun_clr2", int'(bus.overrun), 0);
        pulse_done();
        check_eq("t5_busy_done", int'(bus.busy), 0);

        // Receive error mid-frame.
        frame(40, 8'h10, 0);
        send(8'hEE, 1'b1, 1'b0);
        exp_addr = 0;
        check_eq("t3_frame_err", int'(bus.frame_err), 1);
        check_eq("t3_busy", int'(bus.busy), 0);
        frame(HDR, 8'h30, 0);
        idle(2);
        pulse_done();
        pulse_clear();
        check_eq("t3_frame_err_clr", int'(bus.frame_err), 0);

        // Inter-byte timeout.
        frame(10, 8'h60, 0);
        idle(TMO - 1);
        check_eq("t4_timeout_early", int'(bus.timeout), 0);
        check_eq("t4_busy_early", int'(bus.busy), 1);
        idle(1);
        check_eq("t4_timeout", int'(bus.timeout), 1);
        check_eq("t4_busy_idle", int'(bus.busy), 0);
        exp_addr = 0;
        send(8'h5A, 1'b0, 1'b1);
        idle(TMO + 4);
        exp_addr = 0;
        pulse_clear();
        check_eq("t4_timeout_clr", int'(bus.timeout), 0);

        // Asynchronous reset mid-frame.
        frame(50, 8'h00, 0);
        ld_q.delete();
        n_rst = 1'b0;
        #1;
        check_eq("t6_load", int'(bus.load), 0);
        check_eq("t6_address", int'(bus.address), 0);
        check_eq("t6_load_data", int'(bus.load_data), 0);
        check_eq("t6_busy", int'(bus.busy), 0);
        idle(2);
        n_rst = 1'b1;
        exp_addr = 0;
        idle(1);
        frame(HDR, 8'hB0, 0);
        idle(2);
        pulse_done();
        idle(2);

        check_eq("sb_loads_left", ld_q.size(), 0);
        check_eq("sb_hash_left", hs_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
